// File: rtl/approx_add_arbiter.sv
// approx_add_arbiter: round-robin arbiter in front of one shared median adder,
// followed by a two-stage valid/ready pipeline (S1 operands, S2 result).
// Optional build macro APPROX_ADD_ARB_STATS_EN adds a saturating 16-bit
// output-stall counter on port stall_cnt.

// Median adder: exact sum of the high region, low region forced to 0111..1.
module median_adder #(
    parameter int BITWIDTH = 8,
    parameter int BORDER   = 2,
    parameter int SUBTYPE  = 1
) (
    input  logic [BITWIDTH-1:0] a_i,
    input  logic [BITWIDTH-1:0] b_i,
    output logic [BITWIDTH:0]   sum_o
);
    localparam int W = BITWIDTH - BORDER;

    logic [W-1:0] p;
    logic [W-1:0] g;
    logic [W:0]   c;
    logic         unused_low;

    // The approximate region ignores the operand low bits entirely.
    assign unused_low = ^{a_i[BORDER-1:0], b_i[BORDER-1:0]};

    assign p = a_i[BITWIDTH-1:BORDER] ^ b_i[BITWIDTH-1:BORDER];
    assign g = a_i[BITWIDTH-1:BORDER] & b_i[BITWIDTH-1:BORDER];

    genvar gi;
    generate
        if (SUBTYPE == 0) begin : g_rca
            assign c[0] = 1'b0;
            for (gi = 0; gi < W; gi++) begin : g_ripple
                assign c[gi+1] = g[gi] | (p[gi] & c[gi]);
            end
        end else begin : g_cla
            logic prop;
            // Lookahead carries: c[i+1] = OR_j ( g[j] & p[j+1..i] ), carry-in 0.
            always_comb begin
                c    = '0;
                prop = 1'b0;
                for (int i = 0; i < W; i++) begin
                    for (int j = 0; j <= i; j++) begin
                        prop = 1'b1;
                        for (int k = j + 1; k <= i; k++) begin
                            prop = prop & p[k];
                        end
                        c[i+1] = c[i+1] | (g[j] & prop);
                    end
                end
            end
        end

        assign sum_o[BITWIDTH:BORDER] = {c[W], p ^ c[W-1:0]};
        assign sum_o[BORDER-1]        = 1'b0;
        if (BORDER > 1) begin : g_low_ones
            assign sum_o[BORDER-2:0] = '1;
        end
    endgenerate
endmodule

module approx_add_arbiter #(
    parameter  int NREQ     = 4,
    parameter  int BITWIDTH = 8,
    parameter  int BORDER   = 2,
    parameter  int SUBTYPE  = 1,
    localparam int IDW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*BITWIDTH-1:0] req_a,
    input  logic [NREQ*BITWIDTH-1:0] req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [BITWIDTH:0]        rsp_sum,
    output logic [IDW-1:0]           rsp_id
`ifdef APPROX_ADD_ARB_STATS_EN
    ,
    output logic [15:0]              stall_cnt
`endif
);
    localparam int IDW1 = IDW + 1;

    logic [BITWIDTH-1:0] a_arr [NREQ];
    logic [BITWIDTH-1:0] b_arr [NREQ];

    logic [IDW-1:0]      ptr_q, ptr_d;
    logic                s1_valid_q, s1_valid_d;
    logic [BITWIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic [IDW-1:0]      s1_id_q, s1_id_d;
    logic                s2_valid_q, s2_valid_d;
    logic [BITWIDTH:0]   s2_sum_q, s2_sum_d;
    logic [IDW-1:0]      s2_id_q, s2_id_d;

    logic                grant_found;
    logic [IDW-1:0]      grant_idx;
    logic [IDW:0]        cand_w;
    logic [IDW:0]        ptr_inc;
    logic                s2_load, s1_adv, s1_load, accept;
    logic [BITWIDTH:0]   ma_sum;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign a_arr[gi] = req_a[gi*BITWIDTH +: BITWIDTH];
            assign b_arr[gi] = req_b[gi*BITWIDTH +: BITWIDTH];
        end
    endgenerate

    // Round-robin search: first valid requester starting at ptr, wrapping modulo NREQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_w      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand_w = {1'b0, ptr_q} + IDW1'(k);
            if (cand_w >= IDW1'(NREQ)) begin
                cand_w = cand_w - IDW1'(NREQ);
            end
            if (!grant_found && req_valid[cand_w[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand_w[IDW-1:0];
            end
        end
    end

    assign s2_load = !s2_valid_q | rsp_ready;
    assign s1_adv  = s1_valid_q & s2_load;
    assign s1_load = !s1_valid_q | s1_adv;
    // Ready is held low throughout reset even though S1 reads as empty then.
    assign accept  = grant_found & s1_load & !rst;
    assign ptr_inc = {1'b0, grant_idx} + IDW1'(1);

    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_ready
            assign req_ready[gi] = accept && (grant_idx == IDW'(gi));
        end
    endgenerate

    median_adder #(
        .BITWIDTH (BITWIDTH),
        .BORDER   (BORDER),
        .SUBTYPE  (SUBTYPE)
    ) u_ma (
        .a_i   (s1_a_q),
        .b_i   (s1_b_q),
        .sum_o (ma_sum)
    );

    // Next state for pointer and both pipeline stages.
    always_comb begin
        ptr_d      = ptr_q;
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_id_d    = s1_id_q;
        s2_valid_d = s2_valid_q;
        s2_sum_d   = s2_sum_q;
        s2_id_d    = s2_id_q;
        if (accept) begin
            ptr_d   = (ptr_inc >= IDW1'(NREQ)) ? '0 : ptr_inc[IDW-1:0];
            s1_a_d  = a_arr[grant_idx];
            s1_b_d  = b_arr[grant_idx];
            s1_id_d = grant_idx;
        end
        if (s1_load) begin
            s1_valid_d = accept;
        end
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
        end
        if (s1_adv) begin
            s2_sum_d = ma_sum;
            s2_id_d  = s1_id_q;
        end
    end

    // State registers; reset discards anything in flight and restarts at requester 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_id_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_sum_q   <= '0;
            s2_id_q    <= '0;
        end else begin
            ptr_q      <= ptr_d;
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_id_q    <= s1_id_d;
            s2_valid_q <= s2_valid_d;
            s2_sum_q   <= s2_sum_d;
            s2_id_q    <= s2_id_d;
        end
    end

    assign rsp_valid = s2_valid_q;
    assign rsp_sum   = s2_sum_q;
    assign rsp_id    = s2_id_q;

`ifdef APPROX_ADD_ARB_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Count cycles where a result waits on the consumer, saturating at all ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (s2_valid_q && !rsp_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Stall counter register, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif
endmodule
